md_unit: RTL

- Iterative multiply/divide unit with its HI/LO registers, in the EX stage directly downstream of the instruction decoder.
- Consumes the decoder's MD control fields (function code and sign select) plus the EX-stage rs/rt operand values.
- Drives HI/LO for the mfhi/mflo writeback path.
- Drives a busy flag, which stall detection uses to hold any MD-touching instruction.

---
 rtl/md_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with HI/LO registers for the EX stage.
// mult/multu: single-cycle product staged and released after MUL_LAT busy cycles.
// div/divu: restoring radix-2 divider on magnitudes, one quotient bit per cycle,
// followed by a one-cycle sign fixup.
// Optional build macro MD_DIV_EARLY_OUT_EN: a divide whose dividend magnitude is
// below the divisor magnitude skips the iteration and finishes in one busy cycle.
module md_unit #(
  parameter int MUL_LAT = 5,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       md_func,
  input  logic             md_sign,
  input  logic             md_valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  // Counter must hold both MUL_LAT-1 and WIDTH-1.
  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [2:0] FN_MTHI = 3'd1;
  localparam logic [2:0] FN_MTLO = 3'd2;
  localparam logic [2:0] FN_MUL  = 3'd3;
  localparam logic [2:0] FN_DIV  = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    DIV     = 2'd2,
    DIV_FIX = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_magB;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_negQ;
  logic               r_negR;
  logic               r_done;

  logic               w_idle;
  logic               w_accMthi;
  logic               w_accMtlo;
  logic               w_accMul;
  logic               w_accDiv;
  logic [2*WIDTH-1:0] w_extA;
  logic [2*WIDTH-1:0] w_extB;
  logic [2*WIDTH-1:0] w_product;
  logic               w_negA;
  logic               w_negB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_remShift;
  logic               w_trialOk;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quotNext;
  logic               w_earlyOut;
  logic               w_mulLast;
  logic               w_divLast;
  logic [WIDTH-1:0]   w_fixLo;
  logic [WIDTH-1:0]   w_fixHi;

  // Request decode: only a valid instruction arriving while idle is taken;
  // function codes 5..7 fall through as no-ops.
  assign w_idle    = (r_state == IDLE);
  assign w_accMthi = md_valid && w_idle && (md_func == FN_MTHI);
  assign w_accMtlo = md_valid && w_idle && (md_func == FN_MTLO);
  assign w_accMul  = md_valid && w_idle && (md_func == FN_MUL);
  assign w_accDiv  = md_valid && w_idle && (md_func == FN_DIV);

  // Multiply: extending both operands to 2*WIDTH makes the truncated product
  // correct for both two's-complement and unsigned interpretations.
  assign w_extA    = md_sign ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign w_extB    = md_sign ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign w_product = w_extA * w_extB;

  // Divide operand magnitudes; the most negative value negates to itself,
  // which is the correct unsigned magnitude.
  assign w_negA = md_sign & src_a[WIDTH-1];
  assign w_negB = md_sign & src_b[WIDTH-1];
  assign w_magA = w_negA ? -src_a : src_a;
  assign w_magB = w_negB ? -src_b : src_b;

  // One restoring step: shift {rem,quot} left, subtract divisor when it fits.
  // The shifted remainder needs WIDTH+1 bits; a successful difference always
  // fits back into WIDTH bits because it is smaller than the divisor.
  assign w_remShift = {r_rem, r_quot[WIDTH-1]};
  assign w_trialOk  = (w_remShift >= {1'b0, r_magB});
  assign w_remNext  = w_trialOk ? (w_remShift[WIDTH-1:0] - r_magB) : w_remShift[WIDTH-1:0];
  assign w_quotNext = {r_quot[WIDTH-2:0], w_trialOk};

`ifdef MD_DIV_EARLY_OUT_EN
  // A zero divisor can never satisfy this, so divide by zero still iterates.
  assign w_earlyOut = (w_magA < w_magB);
`else
  assign w_earlyOut = 1'b0;
`endif

  assign w_mulLast = (r_state == MUL) && (r_cnt == '0);
  assign w_divLast = (r_state == DIV_FIX);

  // Sign fixup: quotient negative when operand signs differ, remainder takes
  // the dividend's sign.
  assign w_fixLo = r_negQ ? -r_quot : r_quot;
  assign w_fixHi = r_negR ? -r_rem : r_rem;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: mul waits out its latency, div iterates then fixes signs.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_accMul) begin
          w_stateNext = MUL;
        end else if (w_accDiv) begin
          w_stateNext = w_earlyOut ? DIV_FIX : DIV;
        end
      end
      MUL: begin
        if (r_cnt == '0) begin
          w_stateNext = IDLE;
        end
      end
      DIV: begin
        if (r_cnt == '0) begin
          w_stateNext = DIV_FIX;
        end
      end
      DIV_FIX: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Step counter: loaded at accept, counts down to the final mul/div cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accMul) begin
      r_cnt <= CNT_W'(MUL_LAT - 1);
    end else if (w_accDiv) begin
      r_cnt <= CNT_W'(WIDTH - 1);
    end else if (((r_state == MUL) || (r_state == DIV)) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Working registers: staged product, divider remainder/quotient and signs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_magB <= '0;
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accMul) begin
            r_prod <= w_product;
          end
          if (w_accDiv) begin
            r_magB <= w_magB;
            r_negQ <= w_negA ^ w_negB;
            r_negR <= w_negA;
            if (w_earlyOut) begin
              r_quot <= '0;
              r_rem  <= w_magA;
            end else begin
              r_quot <= w_magA;
              r_rem  <= '0;
            end
          end
        end
        DIV: begin
          r_quot <= w_quotNext;
          r_rem  <= w_remNext;
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural HI/LO: written by mthi/mtlo at accept, or by a finishing
  // mul/div; otherwise held so they stay stable through the busy window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_accMthi) begin
        r_hi <= src_a;
      end
      if (w_accMtlo) begin
        r_lo <= src_a;
      end
      if (w_mulLast) begin
        r_hi <= r_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_prod[WIDTH-1:0];
      end
      if (w_divLast) begin
        r_hi <= w_fixHi;
        r_lo <= w_fixLo;
      end
    end
  end

  // Completion pulse, high in the first cycle the new HI/LO are visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_mulLast | w_divLast;
    end
  end

  assign busy = (r_state != IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule
